presence_filter: RTL

Distance-to-presence conditioning stage for the fan controller. It periodically samples the raw 12-bit centimetre distance from the ultrasonic ranger and median-filters it over three samples. A hysteresis state machine with a hold timer turns the filtered value into a stable `present` level and a one-cycle `away_off` pulse. The pulse drives the motor speed controller's auto-off input, replacing the raw single-threshold distance compare.

---
 rtl/presence_filter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/presence_filter.sv
// presence_filter: samples the ranger distance periodically, median-filters
// the last three valid samples, and converts the result into a stable
// presence level plus a one-cycle auto-off pulse after a hold time.
module presence_filter #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_MS = 100,
    parameter int unsigned NEAR_CM   = 20,
    parameter int unsigned FAR_CM    = 32,
    parameter int unsigned HOLD_S    = 3
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [11:0] distance,
    input  logic        enable,
    output logic        present,
    output logic        away_off,
    output logic [11:0] filtered_cm
);

    // Products are formed in 64 bits; SAMPLE_MS*CLK_HZ exceeds 32 bits at defaults.
    localparam int unsigned TICKS  = int'((64'(SAMPLE_MS) * 64'(CLK_HZ)) / 64'd1000);
    localparam int unsigned HOLD   = int'(64'(HOLD_S) * 64'(CLK_HZ));
    localparam int unsigned TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        ABSENT,
        PRESENT,
        LEAVING
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [11:0]         w0, w1, w2;
    logic [1:0]          fill;
    logic                accepted;
    logic                eval;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [11:0]         lo_ab, hi_ab, mid_c, median;
    logic                is_near, is_far;

    assign tick    = (tick_cnt == TICK_W'(TICKS - 1));
    assign is_near = (filtered_cm != '0) && (filtered_cm <= 12'(NEAR_CM));
    assign is_far  = (filtered_cm >= 12'(FAR_CM));

    // Free-running sample period counter, wraps after TICKS cycles.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Shift valid (nonzero) samples into the window; count fill up to 3.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
            fill     <= '0;
            accepted <= 1'b0;
        end else begin
            accepted <= 1'b0;
            if (tick && (distance != '0)) begin
                w0       <= distance;
                w1       <= w0;
                w2       <= w1;
                accepted <= 1'b1;
                if (fill != 2'd3) begin
                    fill <= fill + 2'd1;
                end
            end
        end
    end

    // Median of three via compare-swap: max(min(a,b), min(max(a,b),c)).
    always_comb begin
        lo_ab  = (w0 < w1) ? w0 : w1;
        hi_ab  = (w0 < w1) ? w1 : w0;
        mid_c  = (hi_ab < w2) ? hi_ab : w2;
        median = (lo_ab > mid_c) ? lo_ab : mid_c;
    end

    // Register the median once the window is full and strobe eval with it.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            filtered_cm <= '0;
            eval        <= 1'b0;
        end else begin
            eval <= accepted && (fill == 2'd3);
            if (accepted && (fill == 2'd3)) begin
                filtered_cm <= median;
            end
        end
    end

    // Hysteresis state machine with hold timer; cancel beats hold expiry.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state    <= ABSENT;
            hold_cnt <= '0;
            present  <= 1'b0;
            away_off <= 1'b0;
        end else begin
            away_off <= 1'b0;
            if (!enable) begin
                state    <= ABSENT;
                hold_cnt <= '0;
                present  <= 1'b0;
            end else begin
                case (state)
                    ABSENT: begin
                        if (eval && is_near) begin
                            state   <= PRESENT;
                            present <= 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (eval && is_far) begin
                            state    <= LEAVING;
                            hold_cnt <= '0;
                        end
                    end
                    LEAVING: begin
                        if (eval && is_near) begin
                            state    <= PRESENT;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_W'(HOLD - 1)) begin
                            state    <= ABSENT;
                            hold_cnt <= '0;
                            present  <= 1'b0;
                            away_off <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state    <= ABSENT;
                        hold_cnt <= '0;
                        present  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
